// File: rtl/fence_t_seq_if.sv
// Handshake and control bundle of the fence.t sequencer.
// The master side is the controller environment, the slave side is the sequencer.
interface fence_t_seq_if #(
  parameter int NUM_DRAIN = 2,
  parameter int PAD_W     = 32,
  parameter int NUM_SRC   = 2
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                 clr_i;
  logic                 fence_t_i;
  logic                 pad_en_i;
  logic [PAD_W-1:0]     pad_i;
  logic [SEL_W-1:0]     src_sel_i;
  logic [NUM_SRC-1:0]   src_evt_i;
  logic                 flush_ack_i;
  logic [NUM_DRAIN-1:0] busy_i;

  logic                 flush_req_o;
  logic                 halt_o;
  logic                 stall_o;
  logic                 clr_o;
  logic                 cache_init_no;
  logic [PAD_W-1:0]     ceil_o;
  logic                 ceil_valid_o;
  logic                 drain_err_o;
  logic                 busy_o;

  modport master (
    output clr_i, fence_t_i, pad_en_i, pad_i,
    output src_sel_i, src_evt_i, flush_ack_i, busy_i,
    input  flush_req_o, halt_o, stall_o, clr_o,
    input  cache_init_no, ceil_o, ceil_valid_o,
    input  drain_err_o, busy_o
  );

  modport slave (
    input  clr_i, fence_t_i, pad_en_i, pad_i,
    input  src_sel_i, src_evt_i, flush_ack_i, busy_i,
    output flush_req_o, halt_o, stall_o, clr_o,
    output cache_init_no, ceil_o, ceil_valid_o,
    output drain_err_o, busy_o
  );
endinterface

// File: rtl/fence_t_seq.sv
// fence.t microreset sequencer: flush, multi-channel drain,
// optional pad to a timing boundary, then a uarch clear pulse.
module fence_t_seq #(
  parameter int NUM_DRAIN     = 2,
  parameter int DRAIN_IDLE    = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CLR_CYCLES    = 16,
  parameter int INIT_HOLD     = 3,
  parameter int PAD_W         = 32,
  parameter int NUM_SRC       = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  fence_t_seq_if.slave bus
);
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IDL_W  = (DRAIN_IDLE > 1) ? $clog2(DRAIN_IDLE) : 1;
  localparam int CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int HLD_W  = (INIT_HOLD > 0) ? $clog2(INIT_HOLD + 1) : 1;
  localparam int TO_MAX = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT : 1;
  localparam int TO_W   = $clog2(TO_MAX + 1);

  localparam bit               TO_ON    = (DRAIN_TIMEOUT != 0);
  localparam logic [IDL_W-1:0] IDL_SAT  = IDL_W'(DRAIN_IDLE - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LD   = HLD_W'(INIT_HOLD);
  localparam logic [TO_W-1:0]  TO_SAT   = TO_W'(TO_MAX);
  localparam logic [TO_W-1:0]  TO_HIT   = TO_W'(TO_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_PAD,
    S_RST
  } state_t;

  state_t state;
  state_t state_n;

  logic [NUM_SRC-1:0] evt_q;
  logic               load;
  logic [PAD_W-1:0]   pad_cnt;
  logic [IDL_W-1:0]   idle_cnt [NUM_DRAIN];
  logic               drained;
  logic [CLR_W-1:0]   clr_cnt;
  logic [HLD_W-1:0]   hold_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [PAD_W-1:0]   ceil_s;
  logic [PAD_W-1:0]   ceil_q;
  logic               ceil_v_q;
  logic               err_q;
  logic               start;
  logic               drain_done;
  logic               rst_done;

  // An out-of-range select matches no source and never loads.
  always_comb begin
    load = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_sel_i == SEL_W'(i)) begin
        load = bus.src_evt_i[i] & ~evt_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else if (bus.clr_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= bus.src_evt_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pad_cnt <= '0;
    end else if (bus.clr_i) begin
      pad_cnt <= '0;
    end else if (load) begin
      pad_cnt <= bus.pad_i;
    end else if (pad_cnt != '0) begin
      pad_cnt <= pad_cnt - PAD_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_DRAIN; k++) begin
        idle_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_DRAIN; k++) begin
        if (bus.clr_i || bus.busy_i[k]) begin
          idle_cnt[k] <= '0;
        end else if (idle_cnt[k] != IDL_SAT) begin
          idle_cnt[k] <= idle_cnt[k] + IDL_W'(1);
        end
      end
    end
  end

  always_comb begin
    drained = ~|bus.busy_i;
    for (int k = 0; k < NUM_DRAIN; k++) begin
      if (idle_cnt[k] != IDL_SAT) begin
        drained = 1'b0;
      end
    end
  end

  // Elapsed cycles since the last trigger; 0 when the pad has expired.
  assign ceil_s = (pad_cnt == '0) ? '0 : bus.pad_i - pad_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    drain_done = 1'b0;
    rst_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.fence_t_i) begin
          state_n = S_FLUSH;
          start   = 1'b1;
        end
      end
      S_FLUSH: begin
        if (bus.flush_ack_i) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          drain_done = 1'b1;
          state_n    = bus.pad_en_i ? S_PAD : S_RST;
        end
      end
      S_PAD: begin
        if (pad_cnt == '0) begin
          state_n = S_RST;
        end
      end
      S_RST: begin
        if (clr_cnt == CLR_LAST) begin
          rst_done = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clr_cnt <= '0;
    end else if (state == S_RST && !rst_done) begin
      clr_cnt <= clr_cnt + CLR_W'(1);
    end else begin
      clr_cnt <= '0;
    end
  end

  // Hold runs on its own, so a fence started inside it cannot cut it short.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt <= '0;
    end else if (rst_done) begin
      hold_cnt <= HLD_LD;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HLD_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt <= '0;
    end else if (state != S_DRAIN) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_SAT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (TO_ON && state == S_DRAIN && to_cnt == TO_HIT) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ceil_q   <= '0;
      ceil_v_q <= 1'b0;
    end else begin
      ceil_v_q <= drain_done;
      if (drain_done) begin
        ceil_q <= ceil_s;
      end
    end
  end

  assign bus.flush_req_o   = (state == S_FLUSH);
  assign bus.halt_o        = (state != S_IDLE);
  assign bus.busy_o        = (state != S_IDLE);
  assign bus.stall_o       = (state == S_DRAIN) ||
                             (state == S_PAD) ||
                             (state == S_RST);
  assign bus.clr_o         = (state == S_RST);
  assign bus.cache_init_no = (state == S_RST) || (hold_cnt != '0);
  assign bus.ceil_o        = ceil_q;
  assign bus.ceil_valid_o  = ceil_v_q;
  assign bus.drain_err_o   = err_q;

endmodule

// File: tb/tb_fence_t_seq.sv
// Bench for fence_t_seq: directed tables and sequences plus random
// stimulus against a cycle-count reference model.
module tb_fence_t_seq;
  localparam int NUM_DRAIN     = 2;
  localparam int DRAIN_IDLE    = 16;
  localparam int DRAIN_TIMEOUT = 1024;
  localparam int CLR_CYCLES    = 16;
  localparam int INIT_HOLD     = 3;
  localparam int PAD_W         = 32;
  localparam int NUM_SRC       = 2;

  localparam int P_IDLE  = 0;
  localparam int P_FLUSH = 1;
  localparam int P_DRAIN = 2;
  localparam int P_PAD   = 3;
  localparam int P_RST   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_clr = 1'b0;
  logic clr_drv = 1'b0;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  fence_t_seq_if #(
    .NUM_DRAIN(NUM_DRAIN),
    .PAD_W(PAD_W),
    .NUM_SRC(NUM_SRC)
  ) bus ();

  fence_t_seq #(
    .NUM_DRAIN(NUM_DRAIN),
    .DRAIN_IDLE(DRAIN_IDLE),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .CLR_CYCLES(CLR_CYCLES),
    .INIT_HOLD(INIT_HOLD),
    .PAD_W(PAD_W),
    .NUM_SRC(NUM_SRC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  assign bus.clr_i = loop_clr ? bus.clr_o : clr_drv;

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: phases, elapsed-time pad and idle run lengths.
  int          m_cyc;
  int          m_ph;
  int          m_rleft;
  int          m_hold_end;
  int          m_dcyc;
  longint      m_tload;
  longint      m_vload;
  bit          m_err;
  bit          m_cv;
  logic [31:0] m_ceil;
  bit [1:0]    m_prev;
  int          m_run [NUM_DRAIN];

  task automatic m_reset();
    m_cyc = 0;
    m_ph = P_IDLE;
    m_rleft = 0;
    m_hold_end = 0;
    m_dcyc = 0;
    m_tload = 0;
    m_vload = 0;
    m_err = 0;
    m_cv = 0;
    m_ceil = '0;
    m_prev = '0;
    for (int k = 0; k < NUM_DRAIN; k++) m_run[k] = 0;
  endtask

  task automatic m_step();
    longint pc;
    bit     ld;
    bit     drn;
    bit     cin;
    int     sel;
    pc = m_vload - (longint'(m_cyc) - m_tload);
    if (pc < 0) pc = 0;
    sel = int'(bus.src_sel_i);
    ld = (sel < NUM_SRC) && bus.src_evt_i[sel] && !m_prev[sel];
    drn = 1;
    for (int k = 0; k < NUM_DRAIN; k++) begin
      if (bus.busy_i[k] || m_run[k] < DRAIN_IDLE - 1) drn = 0;
    end
    cin = loop_clr ? (m_ph == P_RST) : clr_drv;
    m_cv = 0;
    case (m_ph)
      P_IDLE: if (bus.fence_t_i) begin
        m_ph = P_FLUSH;
        m_err = 0;
      end
      P_FLUSH: if (bus.flush_ack_i) begin
        m_ph = P_DRAIN;
        m_dcyc = 0;
      end
      P_DRAIN: begin
        m_dcyc++;
        if (DRAIN_TIMEOUT != 0 && m_dcyc == DRAIN_TIMEOUT) m_err = 1;
        if (drn) begin
          m_ceil = (pc == 0) ? 32'd0 : bus.pad_i - 32'(pc);
          m_cv = 1;
          if (bus.pad_en_i) m_ph = P_PAD;
          else begin
            m_ph = P_RST;
            m_rleft = CLR_CYCLES;
          end
        end
      end
      P_PAD: if (pc == 0) begin
        m_ph = P_RST;
        m_rleft = CLR_CYCLES;
      end
      default: begin
        m_rleft--;
        if (m_rleft == 0) begin
          m_ph = P_IDLE;
          m_hold_end = m_cyc + 1 + INIT_HOLD;
        end
      end
    endcase
    if (cin) begin
      m_tload = longint'(m_cyc) + 1;
      m_vload = 0;
      m_prev = '0;
      for (int k = 0; k < NUM_DRAIN; k++) m_run[k] = 0;
    end else begin
      if (ld) begin
        m_tload = longint'(m_cyc) + 1;
        m_vload = longint'(bus.pad_i);
      end
      m_prev = bus.src_evt_i;
      for (int k = 0; k < NUM_DRAIN; k++)
        m_run[k] = bus.busy_i[k] ? 0 : m_run[k] + 1;
    end
    m_cyc++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  function automatic logic [7:0] m_exp();
    return {m_ph == P_FLUSH, m_ph != P_IDLE, m_ph >= P_DRAIN,
            m_ph == P_RST,
            (m_ph == P_RST) || (m_cyc < m_hold_end),
            m_cv, m_err, m_ph != P_IDLE};
  endfunction

  function automatic logic [7:0] act8();
    return {bus.flush_req_o, bus.halt_o, bus.stall_o, bus.clr_o,
            bus.cache_init_no, bus.ceil_valid_o, bus.drain_err_o,
            bus.busy_o};
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_ctl", 64'(act8()), 64'(m_exp()));
      chk("model_ceil", 64'(bus.ceil_o), 64'(m_ceil));
    end
  end

  typedef struct {
    int         n;
    logic       fence;
    logic       ack;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [7];
  int   cnt;
  int   w;

  initial begin
    // {flush_req, halt, stall, clr, cache_init_no}
    tbl[0] = '{1, 1'b1, 1'b0, 5'b11000};
    tbl[1] = '{2, 1'b0, 1'b0, 5'b11000};
    tbl[2] = '{1, 1'b0, 1'b1, 5'b01100};
    tbl[3] = '{1, 1'b0, 1'b0, 5'b01111};
    tbl[4] = '{15, 1'b0, 1'b0, 5'b01111};
    tbl[5] = '{3, 1'b0, 1'b0, 5'b00001};
    tbl[6] = '{2, 1'b0, 1'b0, 5'b00000};

    bus.fence_t_i = 1'b0;
    bus.pad_en_i = 1'b0;
    bus.pad_i = '0;
    bus.src_sel_i = '0;
    bus.src_evt_i = '0;
    bus.flush_ack_i = 1'b0;
    bus.busy_i = '0;

    repeat (2) @(negedge clk);
    chk("reset_ctl", 64'(act8()), 64'd0);
    chk("reset_ceil", 64'(bus.ceil_o), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        bus.fence_t_i = tbl[i].fence;
        bus.flush_ack_i = tbl[i].ack;
        @(negedge clk);
        chk($sformatf("t1_vec%0d_%0d", i, j),
            64'({bus.flush_req_o, bus.halt_o, bus.stall_o,
                 bus.clr_o, bus.cache_init_no}),
            64'(tbl[i].exp));
      end
    end
    bus.fence_t_i = 1'b0;
    bus.flush_ack_i = 1'b0;
    repeat (5) @(negedge clk);

    bus.src_sel_i = 1'b1;
    bus.pad_i = 32'd100;
    bus.pad_en_i = 1'b1;
    bus.src_evt_i = 2'b10;
    @(negedge clk);
    for (int k = 0; k <= 105; k++) begin
      if (k == 40) chk("t2_cv_pre", 64'(bus.ceil_valid_o), 64'd0);
      if (k == 41) begin
        chk("t2_cv", 64'(bus.ceil_valid_o), 64'd1);
        chk("t2_ceil", 64'(bus.ceil_o), 64'd40);
      end
      if (k == 42) chk("t2_cv_post", 64'(bus.ceil_valid_o), 64'd0);
      if (k == 61)
        chk("t2_fence_ignored",
            64'({bus.flush_req_o, bus.halt_o}), 64'd1);
      if (k == 100) chk("t2_pad_hold", 64'(bus.clr_o), 64'd0);
      if (k == 101) chk("t2_rst_entry", 64'(bus.clr_o), 64'd1);
      bus.fence_t_i = (k == 0) || (k == 60);
      bus.flush_ack_i = (k == 2);
      bus.busy_i = (k <= 24) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    bus.fence_t_i = 1'b0;
    bus.flush_ack_i = 1'b0;
    bus.busy_i = '0;
    bus.src_evt_i = '0;
    bus.pad_en_i = 1'b0;
    repeat (30) @(negedge clk);

    for (int k = 0; k <= 70; k++) begin
      if (k == 50 || k == 59)
        chk($sformatf("t3_wait_%0d", k),
            64'({bus.stall_o, bus.clr_o}), 64'd2);
      if (k == 60) chk("t3_exit", 64'(bus.clr_o), 64'd1);
      bus.fence_t_i = (k == 0);
      bus.flush_ack_i = (k == 2);
      bus.busy_i[1] = (k >= 3) && (k < 53) && ((k - 3) % 10 == 0);
      bus.busy_i[0] = (k >= 3) && (k <= 20);
      @(negedge clk);
    end
    bus.busy_i = '0;
    repeat (25) @(negedge clk);

    for (int k = 0; k <= 1160; k++) begin
      if (k == 1026) chk("t4_err_pre", 64'(bus.drain_err_o), 64'd0);
      if (k == 1027)
        chk("t4_err_set",
            64'({bus.drain_err_o, bus.stall_o}), 64'd3);
      if (k == 1100)
        chk("t4_still_drain",
            64'({bus.stall_o, bus.clr_o, bus.drain_err_o}), 64'd5);
      if (k == 1118) chk("t4_drain_last", 64'(bus.clr_o), 64'd0);
      if (k == 1119) chk("t4_rst_entry", 64'(bus.clr_o), 64'd1);
      if (k == 1140)
        chk("t4_err_sticky",
            64'({bus.halt_o, bus.drain_err_o}), 64'd1);
      if (k == 1151)
        chk("t4_err_clear",
            64'({bus.flush_req_o, bus.drain_err_o}), 64'd2);
      bus.fence_t_i = (k == 0) || (k == 1150);
      bus.flush_ack_i = (k == 2) || (k == 1153);
      bus.busy_i = (k <= 1102) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    bus.fence_t_i = 1'b0;
    bus.flush_ack_i = 1'b0;
    repeat (40) @(negedge clk);

    loop_clr = 1'b1;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.clr_o) cnt++;
      bus.fence_t_i = (k == 0);
      bus.flush_ack_i = (k == 2);
      bus.pad_en_i = 1'b1;
      @(negedge clk);
    end
    chk("t5_loop_clr_len", 64'(cnt), 64'(CLR_CYCLES));
    chk("t5_loop_idle", 64'(bus.busy_o), 64'd0);
    loop_clr = 1'b0;
    bus.pad_en_i = 1'b0;
    repeat (20) @(negedge clk);

    for (int k = 0; k <= 8; k++) begin
      bus.fence_t_i = (k == 0);
      bus.flush_ack_i = (k == 2);
      @(negedge clk);
    end
    bus.flush_ack_i = 1'b0;
    chk("t5_in_rst", 64'(bus.clr_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk("t5_async_rst",
           64'({bus.clr_o, bus.halt_o, bus.stall_o, bus.busy_o}),
           64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst", 64'(bus.busy_o), 64'd0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5000; i++) begin
      bus.fence_t_i = ($urandom_range(0, 24) == 0);
      bus.flush_ack_i = ($urandom_range(0, 3) == 0);
      bus.busy_i = {($urandom_range(0, 17) == 0),
                    ($urandom_range(0, 17) == 0)};
      bus.pad_en_i = 1'($urandom_range(0, 1));
      bus.pad_i = $urandom_range(0, 120);
      bus.src_sel_i = 1'($urandom_range(0, 1));
      bus.src_evt_i = bus.src_evt_i ^
                      {($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0)};
      clr_drv = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    bus.fence_t_i = 1'b0;
    bus.flush_ack_i = 1'b1;
    bus.busy_i = '0;
    clr_drv = 1'b0;
    w = 0;
    while (bus.busy_o && w < 600) begin
      @(negedge clk);
      w++;
    end
    chk("rand_settle", 64'(bus.busy_o), 64'd0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fence_t_seq.md
Name: fence_t_seq

Overview:
- Parametrised successor of the core's single-channel fence.t microreset sequencer.
- Sequence on fence.t:
  1. Flush the dcache.
  2. Drain NUM_DRAIN independent handshaked interfaces; each must be idle for DRAIN_IDLE consecutive cycles.
  3. Optionally pad to a timing boundary. The pad trigger is selected from NUM_SRC event sources.
  4. Pulse the microarchitectural clear for CLR_CYCLES cycles.
- Adds drain-timeout error reporting and pad bypass.
- Sits in the controller beside the flush logic; drives halt, the cache stall and the global uarch clear.

Parameters:
- NUM_DRAIN, 2, number of busy inputs that must drain.
- DRAIN_IDLE, 16, consecutive idle cycles required per channel (>=1).
- DRAIN_TIMEOUT, 1024, cycles in DRAIN before drain_err_o is set (0 disables the check).
- CLR_CYCLES, 16, length of the clr_o pulse (>=1).
- INIT_HOLD, 3, cycles cache_init_no stays high after RST exits.
- PAD_W, 32, width of the pad counter and the ceiling.
- NUM_SRC, 2, number of pad trigger sources (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clr_i  in  1  synchronous clear (scope defined under Behaviour).
- fence_t_i  in  1  start pulse from commit.
- pad_en_i  in  1  1 = run the PAD state; 0 = skip it.
- pad_i  in  PAD_W  pad reload value (CSR).
- src_sel_i  in  max(1,$clog2(NUM_SRC))  pad trigger select.
- src_evt_i  in  NUM_SRC  level event sources; a rising edge triggers.
- flush_ack_i  in  1  dcache flush acknowledge.
- busy_i  in  NUM_DRAIN  per-interface busy.
- flush_req_o  out  1  dcache flush request.
- halt_o  out  1  halt commit.
- stall_o  out  1  dcache must accept no new requests.
- clr_o  out  1  uarch clear.
- cache_init_no  out  1  suppress cache init.
- ceil_o  out  PAD_W  pad ceiling.
- ceil_valid_o  out  1  one-cycle strobe for ceil_o.
- drain_err_o  out  1  sticky drain-timeout flag.
- busy_o  out  1  sequencer not IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- rst_i is asynchronous. Asserting it mid-sequence returns to IDLE immediately and drops clr_o, stall_o and halt_o.
- clr_i clears only: the pad counter, the source edge registers and the drain idle counters.
  - clr_i does not clear the FSM, the clr/init counters, ceil_o or drain_err_o. This lets clr_o be looped back to clr_i.
- Edge detection: the selected src_evt_i is registered. load = evt & ~evt_q on the selected bit.
  - A change of src_sel_i takes effect in the same cycle.
  - An out-of-range select gives load = 0.
- Pad counter (PAD_W bits, free-running in all states):
  - load has priority and loads pad_i.
  - Otherwise the counter decrements while nonzero and holds at 0.
- Drain idle counter, one per channel:
  - busy_i[k] = 1 clears the counter.
  - Otherwise it increments, saturating at DRAIN_IDLE-1.
  - drained = all counters saturated and busy_i all 0 in that cycle.
  - The counters run in every state.
- FSM states: IDLE, FLUSH, DRAIN, PAD, RST.
  - IDLE: fence_t_i -> FLUSH. fence_t_i in any other state is ignored.
  - FLUSH: flush_req_o = 1 while in this state. flush_ack_i = 1 -> DRAIN (1-cycle minimum stay).
  - DRAIN:
    - When drained, the sampled ceiling is ceil = (pad_cnt==0) ? 0 : pad_i - pad_cnt (mod 2^PAD_W).
    - On that edge ceil_o is registered from the sampled ceiling and ceil_valid_o pulses for the following cycle.
    - Next state: pad_en_i ? PAD : RST.
  - PAD: pad_cnt == 0 -> RST. If no trigger ever loaded the counter, this exits after 1 cycle.
  - RST:
    - clr_o = 1.
    - A counter counts CLR_CYCLES cycles, then the FSM -> IDLE and the counter returns to 0.
    - clr_o is high for exactly CLR_CYCLES cycles.
- halt_o = busy_o = (state != IDLE). This is registered-state based, so the first assertion is one cycle after fence_t_i.
- stall_o = state in {DRAIN, PAD, RST}.
- cache_init_no is high during RST and for INIT_HOLD cycles after the RST->IDLE edge.
  - A new fence starting inside the hold window does not shorten the hold.
- Drain timeout:
  - A counter of cycles spent in DRAIN, saturating.
  - When DRAIN_TIMEOUT is nonzero and the counter reaches DRAIN_TIMEOUT, drain_err_o is set.
  - The FSM keeps waiting; no handshake is abandoned.
  - drain_err_o clears on the next IDLE->FLUSH transition.
- ceil_o holds its value until the next DRAIN exit.

Test Plan:
1. Basic flow, pad_en_i=0, busy all 0 -> FLUSH; then ack -> DRAIN; then PAD skipped; clr_o high exactly 16 cycles; cache_init_no high 19 cycles total; back to IDLE.
2. Pad: pad_i=100, rise src 1 with src_sel_i=1; fence issued; DRAIN exits when pad_cnt=60 -> ceil_o=40 with a 1-cycle ceil_valid_o; RST entered when the count reaches 0.
3. Drain per channel: busy_i[1] toggles high every 10 cycles for 50 cycles, then stays 0 -> DRAIN exits 16 cycles after busy_i[1]'s last falling edge, not earlier; busy_i[0] alone does not block it.
4. Timeout: DRAIN_TIMEOUT=1024, busy_i[0] held high -> drain_err_o rises after 1024 DRAIN cycles and the FSM stays in DRAIN; release busy -> sequence completes; next fence clears drain_err_o.
5. Robustness: fence_t_i re-pulsed during PAD -> ignored. With clr_o looped to clr_i -> the FSM completes RST normally. rst_i asserted mid-RST -> clr_o drops asynchronously and the FSM is in IDLE.
